// File: rtl/cache_stats_unit.sv
// rtl/cache_stats_unit.sv - cache hierarchy hit/miss statistics with snapshot handshake
//
// Purpose:
//   Classifies each cache access (L1 / L2 / L3 hit or full miss) from the
//   hierarchy's hit flags. It keeps saturating live counters for each class
//   and for the total access count. Snapshots of the counters are published
//   through a valid/ack handshake. A snapshot is taken on snap_req, or
//   automatically every WINDOW accesses.
//
// Parameters:
//   CW          width of every counter and snapshot output
//   WINDOW      accesses per automatic snapshot, 0 disables automatic snapshots
//   AUTO_CLEAR  1 zeroes the live counters when a snapshot is captured
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   access_valid  hit flags this cycle belong to one access
//   hit256        L1 hit
//   hit512        L2 hit
//   hit1024       L3 hit
//   clear         synchronous clear of live statistics
//   snap_req      snapshot request (pulse or level)
//   snap_ack      consumer has read the snapshot
//   l1_hits       snapshot of L1 hits
//   l2_hits       snapshot of L2 hits
//   l3_hits       snapshot of L3 hits
//   misses        snapshot of full misses
//   accesses      snapshot of total accesses
//   snap_valid    snapshot outputs are valid and held
//   overflow      sticky, a live counter saturated
//   snap_lost     sticky, a trigger was dropped while a snapshot was pending

module cache_stats_unit #(
   parameter int CW         = 32,
   parameter int WINDOW     = 0,
   parameter bit AUTO_CLEAR = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          access_valid,
   input  logic          hit256,
   input  logic          hit512,
   input  logic          hit1024,
   input  logic          clear,
   input  logic          snap_req,
   input  logic          snap_ack,
   output logic [CW-1:0] l1_hits,
   output logic [CW-1:0] l2_hits,
   output logic [CW-1:0] l3_hits,
   output logic [CW-1:0] misses,
   output logic [CW-1:0] accesses,
   output logic          snap_valid,
   output logic          overflow,
   output logic          snap_lost
);

   localparam logic [CW-1:0] CMAX  = {CW{1'b1}};
   localparam int            WW    = (WINDOW > 1) ? $clog2(WINDOW + 1) : 1;
   localparam logic [WW-1:0] WLAST = WW'(WINDOW - 1);

   typedef enum logic {S_COUNT, S_HOLD} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] live_l1_q, live_l1_d, live_l2_q, live_l2_d, live_l3_q, live_l3_d;
   logic [CW-1:0] live_mi_q, live_mi_d, live_ac_q, live_ac_d;
   logic [CW-1:0] snap_l1_q, snap_l1_d, snap_l2_q, snap_l2_d, snap_l3_q, snap_l3_d;
   logic [CW-1:0] snap_mi_q, snap_mi_d, snap_ac_q, snap_ac_d;
   logic [WW-1:0] win_q, win_d;
   logic          overflow_q, overflow_d;
   logic          snap_lost_q, snap_lost_d;

   logic          acc_en, inc_l1, inc_l2, inc_l3, inc_mi;
   logic          sat_hit, auto_trig, trig, capture;
   logic [CW-1:0] nxt_l1, nxt_l2, nxt_l3, nxt_mi, nxt_ac;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
      return (en && (v != CMAX)) ? v + CW'(1) : v;
   endfunction

   always_comb begin
      // An access coinciding with clear is discarded outright.
      acc_en = access_valid & ~clear;
      inc_l1 = acc_en & hit256;
      inc_l2 = acc_en & ~hit256 & hit512;
      inc_l3 = acc_en & ~hit256 & ~hit512 & hit1024;
      inc_mi = acc_en & ~hit256 & ~hit512 & ~hit1024;

      nxt_l1 = sat_inc(live_l1_q, inc_l1);
      nxt_l2 = sat_inc(live_l2_q, inc_l2);
      nxt_l3 = sat_inc(live_l3_q, inc_l3);
      nxt_mi = sat_inc(live_mi_q, inc_mi);
      nxt_ac = sat_inc(live_ac_q, acc_en);

      sat_hit = (inc_l1 && live_l1_q == CMAX) || (inc_l2 && live_l2_q == CMAX) ||
                (inc_l3 && live_l3_q == CMAX) || (inc_mi && live_mi_q == CMAX) ||
                (acc_en && live_ac_q == CMAX);

      // Window counter wraps to 0 on the access that completes the window.
      auto_trig = 1'b0;
      win_d     = win_q;
      if (WINDOW > 0 && acc_en) begin
         if (win_q == WLAST) begin
            win_d     = '0;
            auto_trig = 1'b1;
         end else begin
            win_d = win_q + WW'(1);
         end
      end

      trig    = ~clear & (snap_req | auto_trig);
      capture = trig & ((state_q == S_COUNT) | snap_ack);

      state_d     = state_q;
      live_l1_d   = nxt_l1;
      live_l2_d   = nxt_l2;
      live_l3_d   = nxt_l3;
      live_mi_d   = nxt_mi;
      live_ac_d   = nxt_ac;
      snap_l1_d   = snap_l1_q;
      snap_l2_d   = snap_l2_q;
      snap_l3_d   = snap_l3_q;
      snap_mi_d   = snap_mi_q;
      snap_ac_d   = snap_ac_q;
      overflow_d  = overflow_q | sat_hit;
      snap_lost_d = snap_lost_q;

      if (capture) begin
         // Snapshot includes the access sampled at this same edge.
         snap_l1_d = nxt_l1;
         snap_l2_d = nxt_l2;
         snap_l3_d = nxt_l3;
         snap_mi_d = nxt_mi;
         snap_ac_d = nxt_ac;
         state_d   = S_HOLD;
         if (AUTO_CLEAR) begin
            live_l1_d = '0;
            live_l2_d = '0;
            live_l3_d = '0;
            live_mi_d = '0;
            live_ac_d = '0;
         end
      end else if (state_q == S_HOLD) begin
         if (trig) begin
            snap_lost_d = 1'b1;
         end else if (snap_ack) begin
            state_d = S_COUNT;
         end
      end

      // clear leaves the snapshot and handshake state alone.
      if (clear) begin
         live_l1_d   = '0;
         live_l2_d   = '0;
         live_l3_d   = '0;
         live_mi_d   = '0;
         live_ac_d   = '0;
         win_d       = '0;
         overflow_d  = 1'b0;
         snap_lost_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_COUNT;
         live_l1_q   <= '0;
         live_l2_q   <= '0;
         live_l3_q   <= '0;
         live_mi_q   <= '0;
         live_ac_q   <= '0;
         snap_l1_q   <= '0;
         snap_l2_q   <= '0;
         snap_l3_q   <= '0;
         snap_mi_q   <= '0;
         snap_ac_q   <= '0;
         win_q       <= '0;
         overflow_q  <= 1'b0;
         snap_lost_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         live_l1_q   <= live_l1_d;
         live_l2_q   <= live_l2_d;
         live_l3_q   <= live_l3_d;
         live_mi_q   <= live_mi_d;
         live_ac_q   <= live_ac_d;
         snap_l1_q   <= snap_l1_d;
         snap_l2_q   <= snap_l2_d;
         snap_l3_q   <= snap_l3_d;
         snap_mi_q   <= snap_mi_d;
         snap_ac_q   <= snap_ac_d;
         win_q       <= win_d;
         overflow_q  <= overflow_d;
         snap_lost_q <= snap_lost_d;
      end
   end

   assign l1_hits    = snap_l1_q;
   assign l2_hits    = snap_l2_q;
   assign l3_hits    = snap_l3_q;
   assign misses     = snap_mi_q;
   assign accesses   = snap_ac_q;
   assign snap_valid = (state_q == S_HOLD);
   assign overflow   = overflow_q;
   assign snap_lost  = snap_lost_q;

endmodule

// File: tb/tb_cache_stats_unit.sv
// tb/tb_cache_stats_unit.sv - scoreboard bench for cache_stats_unit

module tb_cache_stats_unit;

   typedef struct packed {
      logic [31:0] l1;
      logic [31:0] l2;
      logic [31:0] l3;
      logic [31:0] mi;
      logic [31:0] ac;
   } snap_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic av[3], h1[3], h2[3], h3[3], clr[3], req[3], ack[3];
   logic sv[3], ov[3], sl[3];
   logic pv[3], pa[3];

   logic [31:0] a_l1, a_l2, a_l3, a_mi, a_ac;
   logic [31:0] w_l1, w_l2, w_l3, w_mi, w_ac;
   logic [3:0]  s_l1, s_l2, s_l3, s_mi, s_ac;

   int nvec = 0;
   int nmis = 0;
   snap_t q0[$], q1[$], q2[$];

   // 0: defaults, 1: WINDOW=4, 2: CW=4
   cache_stats_unit u_a (
      .clk(clk), .reset(reset), .access_valid(av[0]), .hit256(h1[0]), .hit512(h2[0]),
      .hit1024(h3[0]), .clear(clr[0]), .snap_req(req[0]), .snap_ack(ack[0]),
      .l1_hits(a_l1), .l2_hits(a_l2), .l3_hits(a_l3), .misses(a_mi), .accesses(a_ac),
      .snap_valid(sv[0]), .overflow(ov[0]), .snap_lost(sl[0]));

   cache_stats_unit #(.WINDOW(4)) u_w (
      .clk(clk), .reset(reset), .access_valid(av[1]), .hit256(h1[1]), .hit512(h2[1]),
      .hit1024(h3[1]), .clear(clr[1]), .snap_req(req[1]), .snap_ack(ack[1]),
      .l1_hits(w_l1), .l2_hits(w_l2), .l3_hits(w_l3), .misses(w_mi), .accesses(w_ac),
      .snap_valid(sv[1]), .overflow(ov[1]), .snap_lost(sl[1]));

   cache_stats_unit #(.CW(4)) u_s (
      .clk(clk), .reset(reset), .access_valid(av[2]), .hit256(h1[2]), .hit512(h2[2]),
      .hit1024(h3[2]), .clear(clr[2]), .snap_req(req[2]), .snap_ack(ack[2]),
      .l1_hits(s_l1), .l2_hits(s_l2), .l3_hits(s_l3), .misses(s_mi), .accesses(s_ac),
      .snap_valid(sv[2]), .overflow(ov[2]), .snap_lost(sl[2]));

   function automatic snap_t cur(input int i);
      snap_t r;
      case (i)
         0:       r = {a_l1, a_l2, a_l3, a_mi, a_ac};
         1:       r = {w_l1, w_l2, w_l3, w_mi, w_ac};
         default: r = {28'd0, s_l1, 28'd0, s_l2, 28'd0, s_l3, 28'd0, s_mi, 28'd0, s_ac};
      endcase
      return r;
   endfunction

   function automatic snap_t mk(input int l1, input int l2, input int l3, input int mi, input int ac);
      snap_t r;
      r.l1 = l1; r.l2 = l2; r.l3 = l3; r.mi = mi; r.ac = ac;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_bit(input string nm, input logic act, input logic exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic push(input int i, input snap_t e);
      case (i)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   // Monitor: a new snapshot is on the outputs when snap_valid rises, or when
   // it stays high across an edge that also sampled snap_ack (back-to-back).
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (reset) begin
            pv[i] = 1'b0;
            pa[i] = 1'b0;
         end else begin
            if (sv[i] && (!pv[i] || pa[i])) begin
               snap_t e, a;
               int    n;
               n = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
               if (n == 0) begin
                  nvec++;
                  nmis++;
                  $display("FAIL dut%0d unexpected snapshot: got %h expected none", i, cur(i));
               end else begin
                  case (i)
                     0:       e = q0.pop_front();
                     1:       e = q1.pop_front();
                     default: e = q2.pop_front();
                  endcase
                  a = cur(i);
                  chk($sformatf("dut%0d l1_hits", i), a.l1, e.l1);
                  chk($sformatf("dut%0d l2_hits", i), a.l2, e.l2);
                  chk($sformatf("dut%0d l3_hits", i), a.l3, e.l3);
                  chk($sformatf("dut%0d misses", i), a.mi, e.mi);
                  chk($sformatf("dut%0d accesses", i), a.ac, e.ac);
               end
            end
            pv[i] = sv[i];
            pa[i] = ack[i];
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic acc1(input int i, input logic a, input logic b, input logic c);
      av[i] = 1'b1; h1[i] = a; h2[i] = b; h3[i] = c;
      step();
      av[i] = 1'b0; h1[i] = 1'b0; h2[i] = 1'b0; h3[i] = 1'b0;
   endtask

   task automatic pulse_req(input int i, input snap_t e);
      req[i] = 1'b1;
      push(i, e);
      step();
      req[i] = 1'b0;
   endtask

   task automatic do_ack(input int i);
      ack[i] = 1'b1;
      step();
      ack[i] = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         av[i] = 0; h1[i] = 0; h2[i] = 0; h3[i] = 0; clr[i] = 0; req[i] = 0; ack[i] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk_bit($sformatf("reset dut%0d snap_valid", i), sv[i], 1'b0);
         chk_bit($sformatf("reset dut%0d overflow", i), ov[i], 1'b0);
         chk_bit($sformatf("reset dut%0d snap_lost", i), sl[i], 1'b0);
         chk($sformatf("reset dut%0d accesses", i), cur(i).ac, 0);
         chk($sformatf("reset dut%0d l1_hits", i), cur(i).l1, 0);
      end
      reset = 1'b0;
      step();

      // Classification mix
      repeat (4) acc1(0, 1, 0, 0);
      repeat (3) acc1(0, 0, 1, 0);
      repeat (2) acc1(0, 0, 0, 1);
      acc1(0, 0, 0, 0);
      pulse_req(0, mk(4, 3, 2, 1, 10));
      chk_bit("mix snap_valid after req", sv[0], 1'b1);
      do_ack(0);
      chk_bit("mix snap_valid after ack", sv[0], 1'b0);

      // Priority: all three flags set counts as L1 only
      acc1(0, 1, 1, 1);
      pulse_req(0, mk(1, 0, 0, 0, 1));
      do_ack(0);

      // Lost trigger, then back-to-back capture
      repeat (2) acc1(0, 0, 1, 0);
      pulse_req(0, mk(0, 2, 0, 0, 2));
      av[0] = 1; h3[0] = 1; req[0] = 1;
      step();
      av[0] = 0; h3[0] = 0; req[0] = 0;
      chk_bit("lost snap_lost", sl[0], 1'b1);
      chk("lost held l2_hits", cur(0).l2, 2);
      chk("lost held accesses", cur(0).ac, 2);
      av[0] = 1; ack[0] = 1; req[0] = 1;
      push(0, mk(0, 0, 1, 1, 2));
      step();
      av[0] = 0; ack[0] = 0; req[0] = 0;
      chk_bit("b2b snap_valid", sv[0], 1'b1);
      chk_bit("b2b snap_lost sticky", sl[0], 1'b1);
      do_ack(0);
      chk_bit("b2b snap_valid after ack", sv[0], 1'b0);
      clr[0] = 1;
      step();
      clr[0] = 0;
      chk_bit("clear snap_lost", sl[0], 1'b0);

      // Window of 4, nine consecutive misses
      for (int c = 1; c <= 9; c++) begin
         av[1] = 1;
         ack[1] = (c == 6);
         if (c == 4 || c == 8) push(1, mk(0, 0, 0, 4, 4));
         step();
      end
      av[1] = 0;
      ack[1] = 1;
      step();
      ack[1] = 0;
      pulse_req(1, mk(0, 0, 0, 1, 1));
      do_ack(1);
      chk_bit("window snap_lost", sl[1], 1'b0);

      // Saturation with CW=4
      repeat (15) acc1(2, 1, 0, 0);
      chk_bit("sat overflow at max", ov[2], 1'b0);
      repeat (2) acc1(2, 1, 0, 0);
      chk_bit("sat overflow past max", ov[2], 1'b1);
      pulse_req(2, mk(15, 0, 0, 0, 15));
      do_ack(2);
      repeat (3) acc1(2, 1, 0, 0);
      clr[2] = 1; av[2] = 1; h1[2] = 1; req[2] = 1;
      step();
      clr[2] = 0; av[2] = 0; h1[2] = 0; req[2] = 0;
      chk_bit("sat overflow after clear", ov[2], 1'b0);
      chk_bit("clear ignores trigger", sv[2], 1'b0);
      pulse_req(2, mk(0, 0, 0, 0, 0));
      do_ack(2);

      // Reset while holding a snapshot
      acc1(0, 0, 0, 1);
      pulse_req(0, mk(0, 0, 1, 0, 1));
      chk_bit("hold before reset", sv[0], 1'b1);
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk_bit("async reset snap_valid", sv[0], 1'b0);
      chk("async reset l3_hits", cur(0).l3, 0);
      chk("async reset accesses", cur(0).ac, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      step();

      chk("dut0 pending snapshots", q0.size(), 0);
      chk("dut1 pending snapshots", q1.size(), 0);
      chk("dut2 pending snapshots", q2.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
